// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, handshaked ROM port, IF/ID register with
// redirect flush, stall hold buffer and request drain. Optional: `IF_MISALIGN_TRAP_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_rdy,
  input  logic [31:0] irom_inst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  npc_op,
  input  logic        br,
  input  logic [31:0] ext,
  input  logic [31:0] alu_c,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        misalign
);

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  typedef enum logic [1:0] {IFID_KEEP, IFID_LOAD, IFID_BUBBLE} ifid_op_t;

  state_t      state, state_nxt;
  ifid_op_t    ifid_op;
  logic [31:0] pc, pc_nxt, pc4;
  logic [31:0] hold_buf, drain_addr, ifid_word;
  logic        hold_we, drain_we;
  logic        redirect;
  logic [31:0] target_raw, target;

  assign pc4 = pc + 32'd4;

  always_comb begin
    redirect   = 1'b0;
    target_raw = ex_pc + ext;
    case (npc_op)
      NPC_PC4:  redirect = 1'b0;
      NPC_BR:   redirect = ex_valid & br;
      NPC_JAL:  redirect = ex_valid;
      NPC_JALR: begin
        redirect   = ex_valid;
        target_raw = alu_c & ~32'h1;
      end
    endcase
  end

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic [31:0] TRAP_PC = 32'h0000_0100;
  logic target_bad;
  logic misalign_q;

  assign target_bad = |target_raw[1:0];
  assign target     = target_bad ? TRAP_PC : target_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= redirect & target_bad;
  end
  assign misalign = misalign_q;
`else
  assign target   = {target_raw[31:2], 2'b00};
  assign misalign = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    pc_nxt    = pc;
    ifid_op   = IFID_KEEP;
    ifid_word = irom_inst;
    hold_we   = 1'b0;
    drain_we  = 1'b0;
    irom_req  = 1'b0;
    irom_addr = pc;

    case (state)
      FETCH: begin
        irom_req = 1'b1;
        if (irom_rdy) begin
          if (!stall) begin
            ifid_op = IFID_LOAD;
            pc_nxt  = pc4;
          end else begin
            hold_we   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (!stall) begin
          ifid_op = IFID_BUBBLE;
        end
      end
      HOLD: begin
        if (!stall) begin
          ifid_op   = IFID_LOAD;
          ifid_word = hold_buf;
          pc_nxt    = pc4;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        irom_req  = 1'b1;
        irom_addr = drain_addr;
        if (irom_rdy) state_nxt = FETCH;
        if (!stall)   ifid_op   = IFID_BUBBLE;
      end
      default: state_nxt = FETCH;
    endcase

    if (redirect) begin
      pc_nxt  = target;
      ifid_op = IFID_BUBBLE;
      hold_we = 1'b0;
      if (state == FETCH && !irom_rdy) begin
        state_nxt = DRAIN;
        drain_we  = 1'b1;
      end else if (state == DRAIN && !irom_rdy) begin
        // An outstanding drain keeps its address stable; only the target moves.
        state_nxt = DRAIN;
      end else begin
        state_nxt = FETCH;
      end
    end

    if (rst) irom_req = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      id_inst  <= NOP_INST;
      id_pc    <= 32'h0;
      id_pc4   <= 32'h0;
      id_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      case (ifid_op)
        IFID_LOAD: begin
          id_inst  <= ifid_word;
          id_pc    <= pc;
          id_pc4   <= pc4;
          id_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          id_inst  <= NOP_INST;
          id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: pure datapath holding registers are left unreset; the FSM only reads them after writing.
  always_ff @(posedge clk) begin
    if (hold_we)  hold_buf   <= irom_inst;
    if (drain_we) drain_addr <= pc;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: ROM model with programmable wait states,
// stall/hold, flush, drain, misalign trap and reset-mid-drain scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_rdy;
  logic [31:0] irom_inst;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  npc_op;
  logic        br;
  logic [31:0] ext;
  logic [31:0] alu_c;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        misalign;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int errors = 0;
  int rom_wait = 0;
  int wcnt;
  int hs_watch = 0;
  logic seen_wrong = 1'b0;
  logic [31:0] exp_tgt;
  logic        exp_mis;

  if_stage dut (
    .clk       (clk),
    .rst       (rst),
    .irom_req  (irom_req),
    .irom_addr (irom_addr),
    .irom_rdy  (irom_rdy),
    .irom_inst (irom_inst),
    .stall     (stall),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
    .npc_op    (npc_op),
    .br        (br),
    .ext       (ext),
    .alu_c     (alu_c),
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .id_pc4    (id_pc4),
    .id_valid  (id_valid),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00A0_0093 : {16'hA5A5, a[15:0]};
  endfunction

  assign irom_inst = rom_word(irom_addr);
  assign irom_rdy  = irom_req && (wcnt >= rom_wait);

  always @(posedge clk or posedge rst) begin
    if (rst)                       wcnt <= 0;
    else if (irom_req && !irom_rdy) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  always @(negedge clk) begin
    if (irom_req && irom_rdy && irom_addr == 32'h8) hs_watch <= hs_watch + 1;
    if (id_valid && (id_pc == 32'h14 || id_pc == 32'h18)) seen_wrong <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0;
    npc_op   = 2'd0;
    br       = 1'b0;
    ex_pc    = 32'h0;
    ext      = 32'h0;
    alu_c    = 32'h0;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    clear_ex();
    step();
    step();
    check("rst_req",      irom_req, 0);
    check("rst_inst",     id_inst,  NOP);
    check("rst_pc",       id_pc,    0);
    check("rst_pc4",      id_pc4,   0);
    check("rst_valid",    id_valid, 0);
    check("rst_misalign", misalign, 0);

    rst = 1'b0;
    #1;
    check("first_req",  irom_req,  1);
    check("first_addr", irom_addr, 32'h0);

    step();
    check("c1_inst",  id_inst,   32'h00A0_0093);
    check("c1_pc",    id_pc,     32'h0);
    check("c1_pc4",   id_pc4,    32'h4);
    check("c1_valid", id_valid,  1);
    check("c1_addr",  irom_addr, 32'h4);
    step();
    check("c2_pc",   id_pc,     32'h4);
    check("c2_addr", irom_addr, 32'h8);

    // Stall for three cycles while the word at 0x8 returns.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    id_pc,    32'h4);
      check("stall_valid", id_valid, 1);
      check("stall_req",   irom_req, 0);
    end
    stall = 1'b0;
    step();
    check("unstall_pc",   id_pc,     32'h8);
    check("unstall_inst", id_inst,   32'hA5A5_0008);
    check("unstall_addr", irom_addr, 32'hC);
    check("hs_0x8_once",  hs_watch,  1);

    step();
    check("seq_pc12", id_pc, 32'hC);
    step();
    check("seq_pc16",  id_pc,     32'h10);
    check("pre_jal_a", irom_addr, 32'h14);

    // JAL at 0x10 + 0x20, wrong-path 0x14 in flight.
    ex_valid = 1'b1; npc_op = 2'd2; ex_pc = 32'h10; ext = 32'h20;
    step();
    clear_ex();
    check("jal_valid", id_valid,  0);
    check("jal_inst",  id_inst,   NOP);
    check("jal_addr",  irom_addr, 32'h30);
    step();
    check("jal_tgt_pc",   id_pc,   32'h30);
    check("jal_tgt_inst", id_inst, 32'hA5A5_0030);
    check("jal_tgt_val",  id_valid, 1);

    // Move to 0x18, then make the ROM 2-wait and take a JALR there.
    ex_valid = 1'b1; npc_op = 2'd2; ex_pc = 32'h8; ext = 32'h10;
    step();
    clear_ex();
    rom_wait = 2;
    check("to18_addr", irom_addr, 32'h18);
    ex_valid = 1'b1; npc_op = 2'd3; alu_c = 32'h45;
    step();
    clear_ex();
    check("drain_req",   irom_req,  1);
    check("drain_addr0", irom_addr, 32'h18);
    check("drain_valid", id_valid,  0);
    step();
    check("drain_addr1", irom_addr, 32'h18);
    step();
    check("post_drain_addr",  irom_addr, 32'h44);
    check("post_drain_valid", id_valid,  0);
    step();
    step();
    check("wait44_valid", id_valid, 0);
    step();
    check("jalr_pc",   id_pc,    32'h44);
    check("jalr_inst", id_inst,  32'hA5A5_0044);
    check("jalr_val",  id_valid, 1);
    rom_wait = 0;

    // Redirect and stall in the same cycle: flush wins.
    stall = 1'b1; ex_valid = 1'b1; npc_op = 2'd1; br = 1'b1; ex_pc = 32'h40; ext = 32'h40;
    step();
    clear_ex();
    stall = 1'b0;
    check("flushstall_valid", id_valid,  0);
    check("flushstall_inst",  id_inst,   NOP);
    check("flushstall_addr",  irom_addr, 32'h80);
    step();
    check("br_tgt_pc", id_pc,     32'h80);
    check("br_tgt_a",  irom_addr, 32'h84);

    // Not-taken branch and a jump without ex_valid: no redirect.
    ex_valid = 1'b1; npc_op = 2'd1; br = 1'b0; ext = 32'h100;
    step();
    check("nt_pc",   id_pc,     32'h84);
    check("nt_addr", irom_addr, 32'h88);
    ex_valid = 1'b0; npc_op = 2'd2; ext = 32'h100;
    step();
    check("inv_pc",   id_pc,     32'h88);
    check("inv_addr", irom_addr, 32'h8C);
    clear_ex();

    // Taken branch to misaligned 0x22.
`ifdef IF_MISALIGN_TRAP_EN
    exp_tgt = 32'h100;
    exp_mis = 1'b1;
`else
    exp_tgt = 32'h20;
    exp_mis = 1'b0;
`endif
    ex_valid = 1'b1; npc_op = 2'd1; br = 1'b1; ex_pc = 32'h20; ext = 32'h2;
    step();
    clear_ex();
    check("mis_pulse", misalign,  exp_mis);
    check("mis_addr",  irom_addr, exp_tgt);
    check("mis_valid", id_valid,  0);
    step();
    check("mis_clear", misalign, 0);
    check("mis_pc",    id_pc,    exp_tgt);

    // Reset asserted mid-drain.
    rom_wait = 3;
    ex_valid = 1'b1; npc_op = 2'd2; ex_pc = 32'h0; ext = 32'h200;
    step();
    clear_ex();
    check("rd_req",  irom_req,  1);
    check("rd_addr", irom_addr, exp_tgt + 32'h4);
    rst = 1'b1;
    #1;
    check("rd_rst_req",   irom_req, 0);
    check("rd_rst_valid", id_valid, 0);
    check("rd_rst_inst",  id_inst,  NOP);
    step();
    rst = 1'b0;
    rom_wait = 0;
    #1;
    check("rd_rel_req",  irom_req,  1);
    check("rd_rel_addr", irom_addr, 32'h0);
    step();
    check("rd_rel_pc",   id_pc,    32'h0);
    check("rd_rel_inst", id_inst,  32'h00A0_0093);
    check("rd_rel_val",  id_valid, 1);

    check("wrong_path_never_valid", seen_wrong, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
